// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers a K-step operand tile, then streams it diagonally skewed into an NxN FP8 PE array.
module systolic_operand_feeder #(
    parameter int N     = 2,
    parameter int K_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*N-1:0] in_a,
    input  logic [8*N-1:0] in_b,
    input  logic           in_last,
    output logic [8*N-1:0] a_out,
    output logic [8*N-1:0] b_out,
    output logic           clear_out,
    output logic           busy,
    output logic           done
);
    localparam int TW = $clog2(K_MAX + 2*N);
    localparam int CW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    state_t          state, state_d;
    logic [7:0]      a_buf [K_MAX][N];
    logic [7:0]      b_buf [K_MAX][N];
    logic [TW-1:0]   count, k, t, last_t, t_sel;
    logic [TW-1:0]   d [N];
    logic            accept, last_beat, strm_d;
    logic [8*N-1:0]  a_d, b_d;

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign clear_out = state == CLEAR;
    assign done      = state == DONE;

    always_comb begin
        accept    = in_valid && in_ready;
        last_beat = accept && (in_last || count == TW'(K_MAX-1));
        last_t    = k + TW'(2*N-1);
        strm_d    = (state == CLEAR) || (state == STREAM && t != last_t);
        // Operands are looked up for the step that will be current after this edge.
        t_sel     = (state == STREAM) ? t + TW'(1) : '0;
        a_d       = '0;
        b_d       = '0;
        for (int i = 0; i < N; i++) begin
            d[i] = t_sel - TW'(i);
            if (strm_d && t_sel >= TW'(i) && d[i] < k) begin
                a_d[8*i +: 8] = a_buf[d[i][CW-1:0]][i];
                b_d[8*i +: 8] = b_buf[d[i][CW-1:0]][i];
            end
        end
        state_d = state;
        case (state)
            IDLE:    state_d = last_beat ? CLEAR : IDLE;
            CLEAR:   state_d = STREAM;
            STREAM:  state_d = (t == last_t) ? DONE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            k     <= '0;
            t     <= '0;
            a_out <= '0;
            b_out <= '0;
        end else begin
            state <= state_d;
            a_out <= a_d;
            b_out <= b_d;
            t     <= (state == STREAM) ? t + TW'(1) : '0;
            if (accept) count <= last_beat ? '0 : count + TW'(1);
            if (last_beat) k <= count + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                a_buf[count[CW-1:0]][i] <= in_a[8*i +: 8];
                b_buf[count[CW-1:0]][i] <= in_b[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Transmit side of the FP8 PE array operand interface.
- Accepts a tile of K operand steps over a valid/ready stream and buffers them.
- Pulses the array clear, then drives diagonally skewed FP8 E4M3 operands into the array's row (a) and column (b) edge inputs.
- Pads with zeros until every PE has accumulated and registered its result, then pulses done.

Parameters:
- N, 2: array dimension; number of row lanes and column lanes.
- K_MAX, 8: operand buffer depth; maximum tile depth K.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand step valid.
- in_ready  out  1  feeder can accept a step.
- in_a  in  8*N  A column for this step; lane i in bits [8i+7:8i] feeds row i.
- in_b  in  8*N  B row for this step; lane j feeds column j.
- in_last  in  1  final step of the tile.
- a_out  out  8*N  skewed row operands to the PE array a_in edge.
- b_out  out  8*N  skewed column operands to the PE array b_in edge.
- clear_out  out  1  one-cycle clear to all PEs.
- busy  out  1  high in CLEAR, STREAM and DONE.
- done  out  1  one-cycle pulse; array c_out values are final.

Behaviour:
- All outputs registered. On a clk edge with rst=0: state IDLE, count=0, a_out=0, b_out=0, clear_out=0, done=0, busy=0, buffer contents don't-care.
- Reset asserted mid-tile aborts immediately to IDLE with the same values; the partial tile is discarded.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE:
  - in_ready=1. A beat is accepted when in_valid && in_ready; it is written to buffer[count] and count increments.
  - On an accepted beat with in_last=1, or with count==K_MAX-1: K := count+1, go to CLEAR.
  - A beat arriving when count==K_MAX-1 is therefore the last beat even if in_last=0.
- CLEAR:
  - Lasts one cycle; clear_out=1 and in_ready=0. Go to STREAM with t=0.
- STREAM:
  - Counter t runs 0..K+2N-1, so the state lasts L=K+2N cycles.
  - For the cycle in which t is current, a_out lane i = A[t-i][i] if 0<=t-i<K, else 8'h00.
  - For the same cycle, b_out lane j = B[t-j][j] if 0<=t-j<K, else 8'h00.
  - Outputs are computed one cycle ahead so the registered value matches the current t.
  - Leaving STREAM, a_out and b_out become 0.
- DONE:
  - Lasts one cycle; done=1. Go to IDLE with count=0; in_ready is 1 the following cycle.
- Latency timing: the last operand reaches PE(N-1,N-1) at t=K+2N-3. The PE accumulator updates on that edge and c_out on the next. The two extra zero cycles cover this; zero operands add zero product.
- in_ready=0 outside IDLE. in_valid during busy is ignored and nothing is buffered.
- Lane data is passed unmodified: no FP8 decode, no denormal flush (the PE flushes exp==0 to zero).
- Back-to-back tiles are allowed. Minimum gap from done to the next tile's first accepted beat is 1 cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-STREAM, release -> a_out=b_out=0, busy=0, in_ready=1, done=0; the next tile streams from t=0 correctly.
- N=2, K=1: in_a={0x40,0x38} (row1=2.0, row0=1.0), in_b={0x38,0x40}, in_last=1 -> clear_out for 1 cycle. STREAM L=5:
  - a_out lane0: 38,00,00,00,00; lane1: 00,40,00,00,00.
  - b_out lane0: 40,00,...; lane1: 00,38,00,...
  - done pulses the cycle after t=4.
- N=2, K=3, steps A0..A2 with distinct lane bytes -> a_out lane1 shows A0[1],A1[1],A2[1] at t=1..3 and zeros elsewhere; 7 cycles from clear_out to done.
- K_MAX overflow: 8 beats with in_last=0 -> K=8, in_ready drops after beat 8; a 9th in_valid is not accepted; STREAM lasts 12 cycles.
- Backpressure: in_valid held high during busy -> in_ready=0 and no buffer writes. in_valid gaps during IDLE -> count holds between beats.
- Back-to-back: second tile presented at done+1 -> accepted; its clear_out precedes its first nonzero a_out by exactly 1 cycle.
